// File: rtl/fdma_arbiter_pkg.sv
// Shared types and default widths for the FDMA channel arbiter.
package fdma_arbiter_pkg;

  localparam int unsigned DEF_NCH     = 2;
  localparam int unsigned DEF_AW      = 32;
  localparam int unsigned DEF_DW      = 128;
  localparam int unsigned DEF_TIMEOUT = 65535;
  localparam int unsigned GNT_W       = 3;

  typedef enum logic {
    S_IDLE,
    S_BUSY
  } state_e;

endpackage

// File: rtl/fdma_arbiter_if.sv
// FDMA-engine side of the arbiter: one write and one read packet port.
interface fdma_arbiter_if
  import fdma_arbiter_pkg::*;
#(
  parameter int unsigned AW = DEF_AW,
  parameter int unsigned DW = DEF_DW
);

  logic          pkg_wr_areq;
  logic [AW-1:0] pkg_wr_addr;
  logic [AW-1:0] pkg_wr_size;
  logic [DW-1:0] pkg_wr_data;
  logic          pkg_wr_en;
  logic          pkg_wr_last;

  logic          pkg_rd_areq;
  logic [AW-1:0] pkg_rd_addr;
  logic [AW-1:0] pkg_rd_size;
  logic [DW-1:0] pkg_rd_data;
  logic          pkg_rd_en;
  logic          pkg_rd_last;

  // Arbiter side issues requests and write data
  modport master (
    output pkg_wr_areq, pkg_wr_addr, pkg_wr_size, pkg_wr_data,
    input  pkg_wr_en, pkg_wr_last,
    output pkg_rd_areq, pkg_rd_addr, pkg_rd_size,
    input  pkg_rd_data, pkg_rd_en, pkg_rd_last
  );

  modport slave (
    input  pkg_wr_areq, pkg_wr_addr, pkg_wr_size, pkg_wr_data,
    output pkg_wr_en, pkg_wr_last,
    input  pkg_rd_areq, pkg_rd_addr, pkg_rd_size,
    output pkg_rd_data, pkg_rd_en, pkg_rd_last
  );

endinterface

// File: rtl/fdma_arbiter_dir.sv
// One arbitration direction: pending latch, round-robin select, IDLE/BUSY FSM,
// grant watchdog and en/last demux towards the granted channel.
module fdma_arbiter_dir
  import fdma_arbiter_pkg::*;
#(
  parameter int unsigned NCH     = DEF_NCH,
  parameter int unsigned AW      = DEF_AW,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [NCH-1:0]    i_ch_areq,
  input  logic [NCH*AW-1:0] i_ch_addr,
  input  logic [NCH*AW-1:0] i_ch_size,
  output logic [NCH-1:0]    o_ch_en,
  output logic [NCH-1:0]    o_ch_last,
  output logic              o_pkg_areq,
  output logic [AW-1:0]     o_pkg_addr,
  output logic [AW-1:0]     o_pkg_size,
  input  logic              i_pkg_en,
  input  logic              i_pkg_last,
  output logic              o_busy,
  output logic [GNT_W-1:0]  o_gnt_id,
  output logic              o_tmo_err
);

  localparam int unsigned CW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

  state_e           r_state;
  logic [NCH-1:0]   r_pend;
  logic [GNT_W-1:0] r_gnt;
  logic [GNT_W-1:0] r_rr;
  logic [CW-1:0]    r_cnt;
  logic             r_areq;
  logic [AW-1:0]    r_addr;
  logic [AW-1:0]    r_size;
  logic             r_tmo;

  logic             w_hit;
  logic [GNT_W-1:0] w_sel;
  int unsigned      w_idx;
  logic [NCH-1:0]   w_clr;
  logic [NCH-1:0]   w_pend_d;
  logic [NCH-1:0]   w_gnt_oh;
  logic [CW-1:0]    w_cnt_inc;
  logic             w_tmo;

  // First pending channel strictly after the last grant, wrapping around
  always_comb begin
    w_hit = 1'b0;
    w_sel = '0;
    w_idx = 0;
    for (int unsigned k = 0; k < NCH; k++) begin
      w_idx = (32'(r_rr) + k + 1) % NCH;
      if (!w_hit && (|(r_pend & (NCH'(1) << w_idx)))) begin
        w_hit = 1'b1;
        w_sel = GNT_W'(w_idx);
      end
    end
  end

  always_comb begin
    w_clr = '0;
    if (r_state == S_IDLE && w_hit) w_clr = NCH'(1) << w_sel;
    w_pend_d = (r_pend | i_ch_areq) & ~w_clr;
  end

  assign w_cnt_inc = (r_cnt == CW'(TIMEOUT)) ? r_cnt : r_cnt + CW'(1);
  assign w_tmo     = (TIMEOUT != 0) && (w_cnt_inc == CW'(TIMEOUT));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_pend  <= '0;
      r_gnt   <= '0;
      r_rr    <= GNT_W'(NCH - 1);
      r_cnt   <= '0;
      r_areq  <= 1'b0;
      r_addr  <= '0;
      r_size  <= '0;
      r_tmo   <= 1'b0;
    end else begin
      r_pend <= w_pend_d;
      r_areq <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_hit) begin
            r_gnt   <= w_sel;
            r_rr    <= w_sel;
            r_addr  <= AW'(i_ch_addr >> (AW * w_sel));
            r_size  <= AW'(i_ch_size >> (AW * w_sel));
            r_areq  <= 1'b1;
            r_cnt   <= '0;
            r_state <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (i_pkg_last) begin
            r_state <= S_IDLE;
          end else if (w_tmo) begin
            r_tmo   <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= w_cnt_inc;
          end
        end
      endcase
    end
  end

  assign o_busy     = (r_state == S_BUSY);
  assign w_gnt_oh   = NCH'(1) << r_gnt;
  assign o_ch_en    = (o_busy && i_pkg_en) ? w_gnt_oh : '0;
  assign o_ch_last  = (o_busy && i_pkg_last) ? w_gnt_oh : '0;
  assign o_pkg_areq = r_areq;
  assign o_pkg_addr = r_addr;
  assign o_pkg_size = r_size;
  assign o_gnt_id   = r_gnt;
  assign o_tmo_err  = r_tmo;

endmodule

// File: rtl/fdma_arbiter.sv
// Shares one FDMA master among NCH channel controllers; write and read are
// arbitered independently, this level only adds the data mux/broadcast.
module fdma_arbiter
  import fdma_arbiter_pkg::*;
#(
  parameter int unsigned NCH     = DEF_NCH,
  parameter int unsigned AW      = DEF_AW,
  parameter int unsigned DW      = DEF_DW,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic              ui_clk,
  input  logic              ui_rst,
  input  logic [NCH-1:0]    ch_wr_areq,
  input  logic [NCH*AW-1:0] ch_wr_addr,
  input  logic [NCH*AW-1:0] ch_wr_size,
  input  logic [NCH*DW-1:0] ch_wr_data,
  output logic [NCH-1:0]    ch_wr_en,
  output logic [NCH-1:0]    ch_wr_last,
  input  logic [NCH-1:0]    ch_rd_areq,
  input  logic [NCH*AW-1:0] ch_rd_addr,
  input  logic [NCH*AW-1:0] ch_rd_size,
  output logic [NCH-1:0]    ch_rd_en,
  output logic [NCH-1:0]    ch_rd_last,
  output logic [DW-1:0]     ch_rd_data,
  fdma_arbiter_if.master    fdma,
  output logic              wr_busy,
  output logic              rd_busy,
  output logic [GNT_W-1:0]  wr_gnt_id,
  output logic [GNT_W-1:0]  rd_gnt_id,
  output logic              wr_tmo_err,
  output logic              rd_tmo_err
);

  fdma_arbiter_dir #(
    .NCH     (NCH),
    .AW      (AW),
    .TIMEOUT (TIMEOUT)
  ) u_wr (
    .i_clk      (ui_clk),
    .i_rst      (ui_rst),
    .i_ch_areq  (ch_wr_areq),
    .i_ch_addr  (ch_wr_addr),
    .i_ch_size  (ch_wr_size),
    .o_ch_en    (ch_wr_en),
    .o_ch_last  (ch_wr_last),
    .o_pkg_areq (fdma.pkg_wr_areq),
    .o_pkg_addr (fdma.pkg_wr_addr),
    .o_pkg_size (fdma.pkg_wr_size),
    .i_pkg_en   (fdma.pkg_wr_en),
    .i_pkg_last (fdma.pkg_wr_last),
    .o_busy     (wr_busy),
    .o_gnt_id   (wr_gnt_id),
    .o_tmo_err  (wr_tmo_err)
  );

  fdma_arbiter_dir #(
    .NCH     (NCH),
    .AW      (AW),
    .TIMEOUT (TIMEOUT)
  ) u_rd (
    .i_clk      (ui_clk),
    .i_rst      (ui_rst),
    .i_ch_areq  (ch_rd_areq),
    .i_ch_addr  (ch_rd_addr),
    .i_ch_size  (ch_rd_size),
    .o_ch_en    (ch_rd_en),
    .o_ch_last  (ch_rd_last),
    .o_pkg_areq (fdma.pkg_rd_areq),
    .o_pkg_addr (fdma.pkg_rd_addr),
    .o_pkg_size (fdma.pkg_rd_size),
    .i_pkg_en   (fdma.pkg_rd_en),
    .i_pkg_last (fdma.pkg_rd_last),
    .o_busy     (rd_busy),
    .o_gnt_id   (rd_gnt_id),
    .o_tmo_err  (rd_tmo_err)
  );

  // Idle write port shows zero rather than whatever channel was last granted
  assign fdma.pkg_wr_data = wr_busy ? DW'(ch_wr_data >> (DW * wr_gnt_id)) : '0;
  assign ch_rd_data       = fdma.pkg_rd_data;

endmodule

// File: tb/tb_fdma_arbiter.sv
// Directed bench: dut_a uses the default watchdog, dut_b (TIMEOUT=100) shares
// the channel inputs and is only examined in the watchdog scenario.
module tb_fdma_arbiter;

  logic         ui_clk = 1'b0;
  logic         ui_rst = 1'b0;
  logic [1:0]   ch_wr_areq = '0;
  logic [1:0]   ch_rd_areq = '0;
  logic [63:0]  ch_wr_addr, ch_wr_size, ch_rd_addr, ch_rd_size;
  logic [255:0] ch_wr_data;

  logic [1:0]   ch_wr_en_a, ch_wr_last_a, ch_rd_en_a, ch_rd_last_a;
  logic [127:0] ch_rd_data_a;
  logic         wr_busy_a, rd_busy_a, wr_tmo_a, rd_tmo_a;
  logic [2:0]   wr_gnt_a, rd_gnt_a;

  logic [1:0]   ch_wr_en_b, ch_wr_last_b, ch_rd_en_b, ch_rd_last_b;
  logic [127:0] ch_rd_data_b;
  logic         wr_busy_b, rd_busy_b, wr_tmo_b, rd_tmo_b;
  logic [2:0]   wr_gnt_b, rd_gnt_b;

  logic [31:0]  wa [2] = '{32'h1000_0000, 32'h1100_0000};
  logic [31:0]  ws [2] = '{32'd256, 32'd64};
  logic [31:0]  ra [2] = '{32'h2000_0000, 32'h2100_0000};
  logic [31:0]  rs [2] = '{32'd16, 32'd32};
  logic [127:0] wd [2] = '{128'hA0A1_A2A3_A4A5_A6A7_A8A9_AAAB_ACAD_AEAF,
                           128'hB0B1_B2B3_B4B5_B6B7_B8B9_BABB_BCBD_BEBF};
  logic [127:0] rdat = 128'hC0FF_EE00_1234_5678_9ABC_DEF0_0F1E_2D3C;

  int n_assert = 0;
  int n_fail   = 0;

  fdma_arbiter_if #(.AW(32), .DW(128)) fa ();
  fdma_arbiter_if #(.AW(32), .DW(128)) fb ();

  always #5 ui_clk = ~ui_clk;

  fdma_arbiter #(.NCH(2), .AW(32), .DW(128)) dut_a (
    .ui_clk(ui_clk), .ui_rst(ui_rst),
    .ch_wr_areq(ch_wr_areq), .ch_wr_addr(ch_wr_addr), .ch_wr_size(ch_wr_size),
    .ch_wr_data(ch_wr_data), .ch_wr_en(ch_wr_en_a), .ch_wr_last(ch_wr_last_a),
    .ch_rd_areq(ch_rd_areq), .ch_rd_addr(ch_rd_addr), .ch_rd_size(ch_rd_size),
    .ch_rd_en(ch_rd_en_a), .ch_rd_last(ch_rd_last_a), .ch_rd_data(ch_rd_data_a),
    .fdma(fa), .wr_busy(wr_busy_a), .rd_busy(rd_busy_a),
    .wr_gnt_id(wr_gnt_a), .rd_gnt_id(rd_gnt_a),
    .wr_tmo_err(wr_tmo_a), .rd_tmo_err(rd_tmo_a)
  );

  fdma_arbiter #(.NCH(2), .AW(32), .DW(128), .TIMEOUT(100)) dut_b (
    .ui_clk(ui_clk), .ui_rst(ui_rst),
    .ch_wr_areq(ch_wr_areq), .ch_wr_addr(ch_wr_addr), .ch_wr_size(ch_wr_size),
    .ch_wr_data(ch_wr_data), .ch_wr_en(ch_wr_en_b), .ch_wr_last(ch_wr_last_b),
    .ch_rd_areq(ch_rd_areq), .ch_rd_addr(ch_rd_addr), .ch_rd_size(ch_rd_size),
    .ch_rd_en(ch_rd_en_b), .ch_rd_last(ch_rd_last_b), .ch_rd_data(ch_rd_data_b),
    .fdma(fb), .wr_busy(wr_busy_b), .rd_busy(rd_busy_b),
    .wr_gnt_id(wr_gnt_b), .rd_gnt_id(rd_gnt_b),
    .wr_tmo_err(wr_tmo_b), .rd_tmo_err(rd_tmo_b)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] oh(input int ch);
    return 2'b01 << ch;
  endfunction

  task automatic do_reset();
    @(negedge ui_clk);
    ui_rst = 1'b1;
    @(negedge ui_clk);
    ui_rst = 1'b0;
    #1;
  endtask

  // Pulse in one cycle; the following cycle must not yet show a request
  task automatic pulse(input logic [1:0] wm, input logic [1:0] rm);
    @(negedge ui_clk);
    ch_wr_areq = wm;
    ch_rd_areq = rm;
    @(negedge ui_clk);
    ch_wr_areq = '0;
    ch_rd_areq = '0;
    #1;
    chk("areq_not_early", {fa.pkg_rd_areq, fa.pkg_wr_areq}, 2'b00);
  endtask

  task automatic chk_wr_gnt(input int ch);
    chk("wr_areq", fa.pkg_wr_areq, 1'b1);
    chk("wr_busy", wr_busy_a, 1'b1);
    chk("wr_gnt_id", wr_gnt_a, 3'(ch));
    chk("wr_addr", fa.pkg_wr_addr, wa[ch]);
    chk("wr_size", fa.pkg_wr_size, ws[ch]);
  endtask

  task automatic chk_rd_gnt(input int ch);
    chk("rd_areq", fa.pkg_rd_areq, 1'b1);
    chk("rd_busy", rd_busy_a, 1'b1);
    chk("rd_gnt_id", rd_gnt_a, 3'(ch));
    chk("rd_addr", fa.pkg_rd_addr, ra[ch]);
    chk("rd_size", fa.pkg_rd_size, rs[ch]);
  endtask

  task automatic wr_burst(input int ch, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge ui_clk);
      fa.pkg_wr_en   = 1'b1;
      fa.pkg_wr_last = (i == n - 1);
      #1;
      if (i == 0) chk("wr_areq_one_cycle", fa.pkg_wr_areq, 1'b0);
      chk("wr_en_route", ch_wr_en_a, oh(ch));
      chk("wr_last_route", ch_wr_last_a, (i == n - 1) ? oh(ch) : 2'b00);
      chk("wr_data_mux", fa.pkg_wr_data, wd[ch]);
    end
    @(negedge ui_clk);
    fa.pkg_wr_en   = 1'b0;
    fa.pkg_wr_last = 1'b0;
    #1;
    chk("wr_idle_after_last", wr_busy_a, 1'b0);
    chk("wr_addr_held", fa.pkg_wr_addr, wa[ch]);
  endtask

  initial begin
    ch_wr_addr = {wa[1], wa[0]};
    ch_wr_size = {ws[1], ws[0]};
    ch_rd_addr = {ra[1], ra[0]};
    ch_rd_size = {rs[1], rs[0]};
    ch_wr_data = {wd[1], wd[0]};
    fa.pkg_wr_en = 1'b0; fa.pkg_wr_last = 1'b0;
    fa.pkg_rd_en = 1'b0; fa.pkg_rd_last = 1'b0; fa.pkg_rd_data = rdat;
    fb.pkg_wr_en = 1'b0; fb.pkg_wr_last = 1'b0;
    fb.pkg_rd_en = 1'b0; fb.pkg_rd_last = 1'b0; fb.pkg_rd_data = '0;

    // Reset state
    do_reset();
    chk("rst_busy", {wr_busy_a, rd_busy_a}, 2'b00);
    chk("rst_gnt", {wr_gnt_a, rd_gnt_a}, 6'd0);
    chk("rst_tmo", {wr_tmo_a, rd_tmo_a}, 2'b00);
    chk("rst_areq", {fa.pkg_wr_areq, fa.pkg_rd_areq}, 2'b00);
    chk("rst_addr", {fa.pkg_wr_addr, fa.pkg_rd_addr}, 64'd0);
    chk("rst_wr_data", fa.pkg_wr_data, 128'd0);

    // 1: single ch0 write, 256 beats
    pulse(2'b01, 2'b00);
    @(negedge ui_clk); #1;
    chk_wr_gnt(0);
    wr_burst(0, 256);

    // 2: simultaneous ch0/ch1, then round-robin repeats ch0, ch1
    do_reset();
    pulse(2'b11, 2'b00);
    @(negedge ui_clk); #1;
    chk_wr_gnt(0);
    wr_burst(0, 4);
    @(negedge ui_clk); #1;
    chk_wr_gnt(1);
    wr_burst(1, 4);
    pulse(2'b11, 2'b00);
    @(negedge ui_clk); #1;
    chk_wr_gnt(0);
    wr_burst(0, 3);
    @(negedge ui_clk); #1;
    chk_wr_gnt(1);
    wr_burst(1, 3);

    // 3: write on ch1 and read on ch0 concurrently
    pulse(2'b10, 2'b01);
    @(negedge ui_clk); #1;
    chk_wr_gnt(1);
    chk_rd_gnt(0);
    for (int i = 0; i < 6; i++) begin
      @(negedge ui_clk);
      fa.pkg_wr_en   = 1'b1;
      fa.pkg_wr_last = (i == 5);
      fa.pkg_rd_en   = 1'b1;
      fa.pkg_rd_last = (i == 3);
      #1;
      chk("c_wr_en", ch_wr_en_a, 2'b10);
      chk("c_wr_last", ch_wr_last_a, {(i == 5), 1'b0});
      chk("c_wr_data", fa.pkg_wr_data, wd[1]);
      chk("c_rd_en", ch_rd_en_a, {1'b0, (i <= 3)});
      chk("c_rd_last", ch_rd_last_a, {1'b0, (i == 3)});
      chk("c_rd_busy", rd_busy_a, (i <= 3));
      chk("c_wr_busy", wr_busy_a, 1'b1);
      chk("c_rd_data", ch_rd_data_a, rdat);
    end
    @(negedge ui_clk);
    fa.pkg_wr_en = 1'b0; fa.pkg_wr_last = 1'b0;
    fa.pkg_rd_en = 1'b0; fa.pkg_rd_last = 1'b0;
    #1;
    chk("c_both_idle", {wr_busy_a, rd_busy_a}, 2'b00);

    // 4: ch1 re-pulses while busy on ch1 with ch0 pending
    pulse(2'b10, 2'b00);
    @(negedge ui_clk); #1;
    chk_wr_gnt(1);
    pulse(2'b11, 2'b00);
    wr_burst(1, 3);
    @(negedge ui_clk); #1;
    chk_wr_gnt(0);
    wr_burst(0, 2);
    @(negedge ui_clk); #1;
    chk_wr_gnt(1);
    wr_burst(1, 2);

    // 6: reset mid-burst, with a ch1 pulse inside the reset cycle
    pulse(2'b01, 2'b01);
    @(negedge ui_clk); #1;
    chk_wr_gnt(0);
    chk_rd_gnt(0);
    for (int i = 0; i < 2; i++) begin
      @(negedge ui_clk);
      fa.pkg_wr_en = 1'b1;
    end
    @(negedge ui_clk);
    ui_rst     = 1'b1;
    ch_wr_areq = 2'b10;
    @(negedge ui_clk);
    ui_rst     = 1'b0;
    ch_wr_areq = 2'b00;
    #1;
    chk("mr_busy", {wr_busy_a, rd_busy_a}, 2'b00);
    chk("mr_en_gated", {ch_wr_en_a, ch_wr_last_a}, 4'd0);
    chk("mr_gnt", {wr_gnt_a, rd_gnt_a}, 6'd0);
    chk("mr_addr", {fa.pkg_wr_addr, fa.pkg_wr_size}, 64'd0);
    @(negedge ui_clk);
    fa.pkg_wr_en = 1'b0;
    #1;
    chk("mr_pend_cleared", {fa.pkg_wr_areq, wr_busy_a}, 2'b00);
    pulse(2'b11, 2'b00);
    @(negedge ui_clk); #1;
    chk_wr_gnt(0);

    // 5: watchdog on dut_b (TIMEOUT=100), ch1 pending behind it
    do_reset();
    pulse(2'b11, 2'b00);
    @(negedge ui_clk); #1;
    chk("t_areq", fb.pkg_wr_areq, 1'b1);
    chk("t_gnt", wr_gnt_b, 3'd0);
    for (int k = 1; k <= 101; k++) begin
      @(negedge ui_clk); #1;
      if (k == 99) begin
        chk("t_no_err_early", wr_tmo_b, 1'b0);
        chk("t_busy_early", wr_busy_b, 1'b1);
      end
      if (k == 100) begin
        chk("t_err_set", wr_tmo_b, 1'b1);
        chk("t_idle", wr_busy_b, 1'b0);
        chk("t_default_no_tmo", {wr_busy_a, wr_tmo_a}, 2'b10);
      end
      if (k == 101) begin
        chk("t_next_areq", fb.pkg_wr_areq, 1'b1);
        chk("t_next_gnt", wr_gnt_b, 3'd1);
        chk("t_err_sticky", wr_tmo_b, 1'b1);
        chk("t_rd_err_clear", rd_tmo_b, 1'b0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
